// File: rtl/mod_counter.sv
// Up/down modulo counter with clear, clamped load, wrap/saturate mode,
// enable prescaler and boundary flags. Count range is 0..MAX_VAL.
module mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 9,
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap,
  output logic             ovf_sticky
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] L_MAX     = WIDTH'(MAX_VAL);
  localparam logic [PS_W-1:0]  L_PS_LAST = PS_W'(PRESCALE - 1);

  logic [WIDTH-1:0] r_count;
  logic [PS_W-1:0]  r_presc;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH-1:0] w_count_nxt;
  logic [PS_W-1:0]  w_presc_nxt;
  logic             w_wrap_nxt;
  logic             w_ovf_nxt;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_step;

  assign w_load_clamped = (load_value > L_MAX) ? L_MAX : load_value;
  assign w_step         = enable && (r_presc == L_PS_LAST);

  // Priority: clear > load > prescaled step > hold. wrap defaults low so it
  // is a single-cycle pulse coinciding with the post-wrap count.
  always_comb begin
    w_count_nxt = r_count;
    w_presc_nxt = r_presc;
    w_wrap_nxt  = 1'b0;
    w_ovf_nxt   = r_ovf;
    if (clear) begin
      w_count_nxt = '0;
      w_presc_nxt = '0;
      w_ovf_nxt   = 1'b0;
    end else if (load) begin
      w_count_nxt = w_load_clamped;
      w_presc_nxt = '0;
    end else if (enable) begin
      if (!w_step) begin
        w_presc_nxt = r_presc + PS_W'(1);
      end else begin
        w_presc_nxt = '0;
        if (up_down) begin
          if (r_count < L_MAX) begin
            w_count_nxt = r_count + WIDTH'(1);
          end else begin
            w_ovf_nxt = 1'b1;
            if (!SATURATE) begin
              w_count_nxt = '0;
              w_wrap_nxt  = 1'b1;
            end
          end
        end else begin
          if (r_count != '0) begin
            w_count_nxt = r_count - WIDTH'(1);
          end else begin
            w_ovf_nxt = 1'b1;
            if (!SATURATE) begin
              w_count_nxt = L_MAX;
              w_wrap_nxt  = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_presc <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_presc <= w_presc_nxt;
      r_wrap  <= w_wrap_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign count      = r_count;
  assign at_max     = (r_count == L_MAX);
  assign at_zero    = (r_count == '0);
  assign wrap       = r_wrap;
  assign ovf_sticky = r_ovf;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three instances (wrap, saturate, prescale-by-3)
// share one stimulus stream and are checked against an integer reference model.
module tb_mod_counter;

  localparam int MAXV = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, up_down, clear, load;
  logic [3:0] load_value;

  logic [3:0] cnt   [3];
  logic       amax  [3];
  logic       azero [3];
  logic       wr    [3];
  logic       ovf   [3];

  int total = 0;
  int bad   = 0;

  // reference model state, one slot per instance
  int m_cnt[3], m_ps[3], m_wrap[3], m_ovf[3];
  int m_sat[3] = '{0, 1, 0};
  int m_pre[3] = '{1, 1, 3};

  typedef struct {
    logic       clr, ld;
    logic [3:0] lv;
    logic       en, ud;
    int         ec, ew, eo;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .count(cnt[0]), .at_max(amax[0]),
    .at_zero(azero[0]), .wrap(wr[0]), .ovf_sticky(ovf[0]));

  mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1), .PRESCALE(1)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .count(cnt[1]), .at_max(amax[1]),
    .at_zero(azero[1]), .wrap(wr[1]), .ovf_sticky(ovf[1]));

  mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .PRESCALE(3)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .count(cnt[2]), .at_max(amax[2]),
    .at_zero(azero[2]), .wrap(wr[2]), .ovf_sticky(ovf[2]));

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_ps[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
    end
  endfunction

  // One rising edge: every enabled cycle accumulates, every PRESCALE-th is a step.
  function automatic void model_edge();
    for (int i = 0; i < 3; i++) begin
      m_wrap[i] = 0;
      if (clear) begin
        m_cnt[i] = 0; m_ps[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_value) > MAXV) ? MAXV : int'(load_value);
        m_ps[i]  = 0;
      end else if (enable) begin
        m_ps[i]++;
        if (m_ps[i] == m_pre[i]) begin
          m_ps[i] = 0;
          if (up_down) begin
            if (m_cnt[i] < MAXV) m_cnt[i]++;
            else begin
              m_ovf[i] = 1;
              if (m_sat[i] == 0) begin m_cnt[i] = 0; m_wrap[i] = 1; end
            end
          end else begin
            if (m_cnt[i] > 0) m_cnt[i]--;
            else begin
              m_ovf[i] = 1;
              if (m_sat[i] == 0) begin m_cnt[i] = MAXV; m_wrap[i] = 1; end
            end
          end
        end
      end
    end
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("count[%0d]", i), int'(cnt[i]), m_cnt[i]);
      check($sformatf("at_max[%0d]", i), int'(amax[i]), int'(m_cnt[i] == MAXV));
      check($sformatf("at_zero[%0d]", i), int'(azero[i]), int'(m_cnt[i] == 0));
      check($sformatf("wrap[%0d]", i), int'(wr[i]), m_wrap[i]);
      check($sformatf("ovf[%0d]", i), int'(ovf[i]), m_ovf[i]);
    end
  endtask

  task automatic drive(input bit c, input bit l, input logic [3:0] v,
                       input bit e, input bit u);
    clear = c; load = l; load_value = v; enable = e; up_down = u;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  function automatic void addv(input bit c, input bit l, input logic [3:0] v,
                               input bit e, input bit u,
                               input int ec, input int ew, input int eo);
    vec_t t;
    t.clr = c; t.ld = l; t.lv = v; t.en = e; t.ud = u;
    t.ec = ec; t.ew = ew; t.eo = eo;
    vecs.push_back(t);
  endfunction

  initial begin
    int e3c[5] = '{8, 9, 9, 9, 9};
    int e3o[5] = '{0, 0, 1, 1, 1};
    int e4[11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
    int e4en[11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};

    // expected values below are for the wrap instance (MAX_VAL=9, PRESCALE=1)
    for (int k = 1; k <= 12; k++) begin
      addv(0, 0, 4'd0, 1, 1, k % 10, int'(k == 10), int'(k >= 10));
    end
    addv(1, 0, 4'd0, 1, 1, 0, 0, 0);
    addv(0, 0, 4'd0, 1, 0, 9, 1, 1);
    addv(0, 0, 4'd0, 1, 0, 8, 0, 1);
    addv(0, 1, 4'd13, 1, 1, 9, 0, 1);
    addv(1, 1, 4'd5, 1, 1, 0, 0, 0);
    addv(0, 1, 4'd5, 0, 0, 5, 0, 0);
    addv(0, 0, 4'd2, 0, 1, 5, 0, 0);
    addv(0, 1, 4'd3, 1, 0, 3, 0, 0);
    addv(0, 0, 4'd0, 1, 1, 4, 0, 0);

    rst = 1'b1;
    drive(0, 0, 4'd0, 0, 1);
    model_reset();
    #2;
    check_model();
    @(negedge clk);
    rst = 1'b0;

    // table-driven vectors
    foreach (vecs[n]) begin
      drive(vecs[n].clr, vecs[n].ld, vecs[n].lv, vecs[n].en, vecs[n].ud);
      tick();
      check($sformatf("tab%0d_count", n), int'(cnt[0]), vecs[n].ec);
      check($sformatf("tab%0d_wrap", n), int'(wr[0]), vecs[n].ew);
      check($sformatf("tab%0d_ovf", n), int'(ovf[0]), vecs[n].eo);
    end

    // saturating instance: load 7, five up steps, then down from 0
    drive(1, 0, 4'd0, 0, 1); tick();
    drive(0, 1, 4'd7, 0, 1); tick();
    check("sat_load", int'(cnt[1]), 7);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 4'd0, 1, 1); tick();
      check("sat_up_count", int'(cnt[1]), e3c[k]);
      check("sat_up_wrap", int'(wr[1]), 0);
      check("sat_up_ovf", int'(ovf[1]), e3o[k]);
    end
    drive(1, 0, 4'd0, 0, 1); tick();
    drive(0, 0, 4'd0, 1, 0); tick();
    check("sat_down_count", int'(cnt[1]), 0);
    check("sat_down_ovf", int'(ovf[1]), 1);
    check("sat_down_wrap", int'(wr[1]), 0);

    // prescale-by-3 instance, with a two-cycle enable gap mid-prescale
    drive(1, 0, 4'd0, 0, 1); tick();
    for (int k = 0; k < 11; k++) begin
      drive(0, 0, 4'd0, e4en[k][0], 1); tick();
      check($sformatf("pre_step%0d", k), int'(cnt[2]), e4[k]);
    end

    // async reset between edges while count=6 and one prescale cycle accumulated
    drive(1, 0, 4'd0, 0, 1); tick();
    drive(0, 0, 4'd0, 1, 1);
    for (int k = 0; k < 19; k++) tick();
    check("pre_before_rst", int'(cnt[2]), 6);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_count", int'(cnt[2]), 0);
    check("async_rst_ovf_a", int'(ovf[0]), 0);
    check_model();
    #2;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post_rst%0d", k), int'(cnt[2]), (k == 2) ? 1 : 0);
    end

    // randomized stream against the model
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
            4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
